// File: rtl/led_bar_fill.sv
// Thermometer-fill LED bar: lights one LED every TICK_DIV enabled cycles, then raises a sticky full.
// Optional LED_BAR_FULL_BLINK_EN: once full, the bar blinks all-ones/all-zeros every TICK_DIV cycles.
`timescale 1ns/1ps
module led_bar_fill #(
    parameter int TICK_DIV = 10_000_000,
    parameter int NUM_LEDS = 13
) (
    input  logic                CLOCK,
    input  logic                RESETN,
    input  logic                en,
    output logic [NUM_LEDS-1:0] led,
    output logic                full,
    output logic                step
);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                full_q, full_d;
    logic                step_q, step_d;
    logic [NUM_LEDS-1:0] led_shift;
    logic                terminal;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        led_d     = led_q;
        full_d    = full_q;
        step_d    = 1'b0;
        led_shift = {led_q[NUM_LEDS-2:0], 1'b1};
        terminal  = (div_q == DIV_MAX);
        case (state_q)
            IDLE: begin
                div_d = '0;
                if (en) state_d = FILL;
            end
            FILL: begin
                // en low freezes the divider, even at terminal count
                if (en) begin
                    if (terminal) begin
                        div_d  = '0;
                        led_d  = led_shift;
                        step_d = 1'b1;
                        if (&led_shift) begin
                            state_d = DONE;
                            full_d  = 1'b1;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            DONE: begin
`ifdef LED_BAR_FULL_BLINK_EN
                if (terminal) begin
                    div_d = '0;
                    led_d = ~led_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
`else
                div_d = '0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            div_q   <= '0;
            led_q   <= '0;
            full_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            led_q   <= led_d;
            full_q  <= full_d;
            step_q  <= step_d;
        end
    end

    assign led  = led_q;
    assign full = full_q;
    assign step = step_q;
endmodule
